// File: rtl/processor_pkg.sv
// Processor-wide constants and types: instruction-memory geometry, loader states, opcodes.
// No logic; imported by the loader and by anything that assembles instruction images.
package processor_pkg;

  localparam int IMEM_ADDR_WIDTH = 10;
  localparam int IMEM_MAX_WORDS  = 1024;
  localparam int IWORD_W         = 32;

  typedef enum logic [2:0] {
    IDLE,
    HDR_HI,
    HDR_LO,
    DATA,
    CHECK,
    DONE,
    ERROR
  } loader_state_t;

  // Opcode lives in the top byte of every instruction word
  localparam logic [7:0] OPC_NOP  = 8'h00;
  localparam logic [7:0] OPC_ADDI = 8'h10;
  localparam logic [7:0] OPC_LDI  = 8'h25;
  localparam logic [7:0] OPC_BR   = 8'h40;
  localparam logic [7:0] OPC_HALT = 8'hF0;

  function automatic logic [IWORD_W-1:0] insn(input logic [7:0] opc, input logic [23:0] imm);
    return {opc, imm};
  endfunction

endpackage

// File: rtl/imem_word_assembler.sv
// Packs big-endian bytes into 32-bit words; write pulse registered one cycle after the 4th byte.
// No backpressure of its own: accepts a byte whenever byte_vld is high.
module imem_word_assembler
  import processor_pkg::*;
#(
  parameter int ADDR_WIDTH = IMEM_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  byte_vld,
  input  logic [7:0]            byte_dat,
  output logic                  last_byte,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [IWORD_W-1:0]    mem_wdata,
  output logic [ADDR_WIDTH:0]   word_cnt
);

  logic [IWORD_W-9:0] shift_q;
  logic [1:0]         byte_idx;

  assign last_byte = (byte_idx == 2'd3);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shift_q   <= '0;
      byte_idx  <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      word_cnt  <= '0;
    end else begin
      mem_we <= 1'b0;
      if (clear) begin
        shift_q  <= '0;
        byte_idx <= '0;
        word_cnt <= '0;
      end else if (byte_vld) begin
        byte_idx <= byte_idx + 2'd1;
        if (last_byte) begin
          // word_cnt advances on the same edge the pulse rises, so it counts issued writes
          mem_we    <= 1'b1;
          mem_wdata <= {shift_q, byte_dat};
          mem_addr  <= word_cnt[ADDR_WIDTH-1:0];
          word_cnt  <= word_cnt + 1'b1;
        end else begin
          shift_q <= {shift_q[IWORD_W-17:0], byte_dat};
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: header, big-endian words, XOR checksum -> imem writes; cpu_run once image verified.
// Each word written one cycle after its 4th byte; in_valid gaps simply stall, in_ready only while streaming.
module imem_loader
  import processor_pkg::*;
#(
  parameter int ADDR_WIDTH = IMEM_ADDR_WIDTH,
  parameter int MAX_WORDS  = IMEM_MAX_WORDS
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  load_start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [IWORD_W-1:0]    mem_wdata,
  output logic                  cpu_run,
  output logic                  load_error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  loader_state_t state_q, state_d;
  logic [7:0]    n_hi_q;
  logic [15:0]   n_words_q;
  logic [15:0]   n_next;
  logic [7:0]    chk_q;
  logic          accept;
  logic          restart;
  logic          last_byte;

  assign in_ready   = (state_q == HDR_HI) || (state_q == HDR_LO) ||
                      (state_q == DATA)   || (state_q == CHECK);
  assign accept     = in_valid && in_ready;
  assign restart    = load_start &&
                      ((state_q == IDLE) || (state_q == DONE) || (state_q == ERROR));
  assign n_next     = {n_hi_q, in_data};
  assign cpu_run    = (state_q == DONE);
  assign load_error = (state_q == ERROR);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (load_start) state_d = HDR_HI;
      HDR_HI: if (accept) state_d = HDR_LO;
      HDR_LO: if (accept) begin
        if ((n_next == 16'd0) || (n_next > 16'(MAX_WORDS))) state_d = ERROR;
        else                                                  state_d = DATA;
      end
      DATA:   if (accept && last_byte && (16'(words_loaded) + 16'd1 == n_words_q)) state_d = CHECK;
      CHECK:  if (accept) state_d = (in_data == chk_q) ? DONE : ERROR;
      DONE,
      ERROR:  if (load_start) state_d = HDR_HI;
      default: state_d = IDLE;
    endcase
  end

  // Running XOR covers header and data; the checksum byte itself is only compared
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      chk_q     <= '0;
      n_hi_q    <= '0;
      n_words_q <= '0;
    end else if (restart) begin
      chk_q     <= '0;
      n_hi_q    <= '0;
      n_words_q <= '0;
    end else if (accept && (state_q != CHECK)) begin
      chk_q <= chk_q ^ in_data;
      if (state_q == HDR_HI) n_hi_q    <= in_data;
      if (state_q == HDR_LO) n_words_q <= n_next;
    end
  end

  imem_word_assembler #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_asm (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear     (restart),
    .byte_vld  (accept && (state_q == DATA)),
    .byte_dat  (in_data),
    .last_byte (last_byte),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .word_cnt  (words_loaded)
  );

endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized image loads against a stream-level model of the loader.
module tb_imem_loader;
  import processor_pkg::*;

  localparam int AW = 10;
  localparam int MW = 1024;
  localparam int RDY_LIMIT = 20;

  typedef logic [7:0] byteq_t[$];
  typedef logic [31:0] wordq_t[$];

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          load_start = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_run;
  logic          load_error;
  logic [AW:0]   words_loaded;

  int checks = 0;
  int failures = 0;
  logic [AW+31:0] wq[$];

  always #5 clock = ~clock;

  imem_loader #(.ADDR_WIDTH(AW), .MAX_WORDS(MW)) dut (
    .clock(clock), .reset_n(reset_n), .load_start(load_start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_run(cpu_run), .load_error(load_error), .words_loaded(words_loaded)
  );

  always @(negedge clock) if (mem_we === 1'b1) wq.push_back({mem_addr, mem_wdata});

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not reach its end, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic byteq_t make_image(input wordq_t w, input bit bad);
    byteq_t s;
    logic [7:0] x;
    s.push_back(8'(w.size() >> 8));
    s.push_back(8'(w.size()));
    foreach (w[i]) for (int b = 3; b >= 0; b--) s.push_back(w[i][8*b +: 8]);
    x = 8'h00;
    foreach (s[i]) x ^= s[i];
    if (bad) x ^= 8'($urandom_range(1, 255));
    s.push_back(x);
    return s;
  endfunction

  // mode 0: full rate, 1: one idle cycle between bytes, 2: random idle cycles
  task automatic send(input string tag, input byteq_t s, input int mode);
    for (int i = 0; i < s.size(); i++) begin
      if (i > 0 && mode == 1) begin in_valid = 1'b0; @(negedge clock); end
      if (mode == 2) repeat ($urandom_range(0, 2)) begin in_valid = 1'b0; @(negedge clock); end
      in_valid = 1'b1;
      in_data  = s[i];
      for (int g = 0; !in_ready; g++) begin
        if (g >= RDY_LIMIT) begin chk({tag, ":in_ready_wait"}, in_ready, 1'b1); break; end
        @(negedge clock);
      end
      @(negedge clock);
    end
    in_valid = 1'b0;
  endtask

  task automatic run_load(input string tag, input byteq_t s, input int mode);
    int n;
    logic [7:0] x;
    bit ok;
    wq.delete();
    load_start = 1'b1;
    @(negedge clock);
    load_start = 1'b0;
    chk({tag, ":start_run"}, cpu_run, 1'b0);
    chk({tag, ":start_err"}, load_error, 1'b0);
    chk({tag, ":start_cnt"}, words_loaded, 0);
    chk({tag, ":start_rdy"}, in_ready, 1'b1);
    n = (int'(s[0]) << 8) | int'(s[1]);
    if (n == 0 || n > MW) begin
      send(tag, s[0:1], mode);
      chk({tag, ":hdr_err"}, load_error, 1'b1);
      chk({tag, ":hdr_run"}, cpu_run, 1'b0);
      chk({tag, ":hdr_rdy"}, in_ready, 1'b0);
      repeat (3) @(negedge clock);
      chk({tag, ":hdr_nowrite"}, wq.size(), 0);
    end else begin
      send(tag, s[0:4*n+2], mode);
      x = 8'h00;
      for (int i = 0; i < 4*n+2; i++) x ^= s[i];
      ok = (s[4*n+2] == x);
      chk({tag, ":run"}, cpu_run, ok);
      chk({tag, ":err"}, load_error, !ok);
      chk({tag, ":rdy_after"}, in_ready, 1'b0);
      chk({tag, ":words_loaded"}, words_loaded, n);
      @(negedge clock);
      chk({tag, ":nwrites"}, wq.size(), n);
      for (int i = 0; i < n && i < wq.size(); i++) begin
        chk({tag, ":addr"}, wq[i][AW+31:32], i);
        chk({tag, ":data"}, wq[i][31:0], {s[2+4*i], s[3+4*i], s[4+4*i], s[5+4*i]});
      end
    end
  endtask

  initial begin
    byteq_t s;
    wordq_t w;

    repeat (2) @(negedge clock);
    #2;
    chk("rst:mem_we", mem_we, 1'b0);
    chk("rst:mem_addr", mem_addr, 0);
    chk("rst:mem_wdata", mem_wdata, 0);
    chk("rst:cpu_run", cpu_run, 1'b0);
    chk("rst:load_error", load_error, 1'b0);
    chk("rst:words_loaded", words_loaded, 0);
    chk("rst:in_ready", in_ready, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("idle:in_ready", in_ready, 1'b0);

    s = '{8'h00, 8'h02, 8'h25, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h22};
    run_load("good_full", s, 0);
    s[10] = 8'h23;
    run_load("bad_chk", s, 0);
    repeat (2) @(negedge clock);
    chk("bad_chk:held_err", load_error, 1'b1);
    chk("bad_chk:held_run", cpu_run, 1'b0);

    s = '{8'h00, 8'h00};
    run_load("hdr_zero", s, 0);
    s = '{8'h04, 8'h01};
    run_load("hdr_1025", s, 0);

    s = '{8'h00, 8'h02, 8'h25, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h22};
    run_load("good_gapped", s, 1);

    // reset in the middle of the second word
    w = '{insn(OPC_LDI, 24'h000005), insn(OPC_ADDI, 24'hABCDEF)};
    s = make_image(w, 1'b0);
    wq.delete();
    load_start = 1'b1;
    @(negedge clock);
    load_start = 1'b0;
    send("mid_rst", s[0:8], 0);
    chk("mid_rst:pre_cnt", words_loaded, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst:mem_we", mem_we, 1'b0);
    chk("mid_rst:mem_addr", mem_addr, 0);
    chk("mid_rst:mem_wdata", mem_wdata, 0);
    chk("mid_rst:cpu_run", cpu_run, 1'b0);
    chk("mid_rst:load_error", load_error, 1'b0);
    chk("mid_rst:words_loaded", words_loaded, 0);
    chk("mid_rst:in_ready", in_ready, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    wq.delete();
    in_valid = 1'b1;
    in_data  = 8'h5A;
    repeat (4) @(negedge clock);
    chk("post_rst:in_ready", in_ready, 1'b0);
    chk("post_rst:cpu_run", cpu_run, 1'b0);
    chk("post_rst:nowrite", wq.size(), 0);
    in_valid = 1'b0;
    run_load("post_rst_load", s, 0);

    s = '{8'h00, 8'h01, 8'hF0, 8'h00, 8'h00, 8'h00, 8'hF1};
    run_load("reload_done", s, 0);

    for (int k = 0; k < 8; k++) begin
      w.delete();
      repeat ($urandom_range(1, 6)) w.push_back(insn(8'($urandom), 24'($urandom)));
      run_load("rand", make_image(w, $urandom_range(0, 3) == 0), $urandom_range(0, 2));
    end
    s = '{8'($urandom_range(5, 255)), 8'($urandom)};
    run_load("rand_hdr_big", s, 2);

    w.delete();
    for (int i = 0; i < MW; i++) w.push_back(32'($urandom));
    run_load("max_words", make_image(w, 1'b0), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
